// File: rtl/gp_regfile.sv
// gp_regfile: multi-port general-purpose register file with byte-enable
// writes, same-cycle write-to-read bypass, a per-register busy scoreboard
// for pending loads, and a one-cycle delayed bus data acknowledge.
//
// Read handshake: rd_req is sampled at a rising edge together with sel_x and
// sel_y. At the next edge a/b carry the values read in that cycle, and
// rd_valid says whether both sources were free. A source is free if its busy
// bit is clear, or if it is being written in the same cycle without also
// being locked. a/b update on every cycle regardless of rd_valid, so
// consumers must qualify the data with rd_valid. There is no back-pressure.
//
// This block has no FSM. Its only state is the register array, the busy
// scoreboard and the output registers, and all of it is visible on the ports
// except the array itself.
module gp_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        sel_x,
  input  logic [ADDR_W-1:0]        sel_y,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        sel_z,
  input  logic [1:0]               mem_instr,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     lock_en,
  input  logic [ADDR_W-1:0]        lock_sel,
  input  logic                     data_ack_in,
  output logic                     data_ack_out,
  output logic [DATA_W-1:0]        a,
  output logic [DATA_W-1:0]        b,
  output logic                     rd_valid,
  output logic [(2**ADDR_W)-1:0]   busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W / 8;

  // Only this encoding of mem_instr touches the register file; NOP, mem read
  // and mem write belong to the bus side and leave the array alone.
  localparam logic [1:0] OP_REG_WRITE = 2'b11;

  // Reject parameterisations that cannot be split into whole bytes.
  if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $error("gp_regfile: DATA_W must be a multiple of 8 and at least 8");
  end

  logic [DATA_W-1:0] regs [DEPTH];

  // Decoded per-cycle controls.
  logic              zero_z;
  logic              zero_x;
  logic              zero_y;
  logic              zero_lock;
  logic              wr_en;
  logic              lock_eff;

  // Write datapath.
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_merged;

  // Read datapath and scoreboard next state.
  logic              wr_hit_x;
  logic              wr_hit_y;
  logic              lock_hit_x;
  logic              lock_hit_y;
  logic              x_blocked;
  logic              y_blocked;
  logic [DATA_W-1:0] a_next;
  logic [DATA_W-1:0] b_next;
  logic [DEPTH-1:0]  busy_next;
  logic              rd_valid_next;

  // Index-0 suppression when register 0 is hardwired to zero.
  always_comb begin
    zero_z    = (ZERO_REG != 0) && (sel_z == '0);
    zero_x    = (ZERO_REG != 0) && (sel_x == '0);
    zero_y    = (ZERO_REG != 0) && (sel_y == '0);
    zero_lock = (ZERO_REG != 0) && (lock_sel == '0);
  end

  // Qualify write and lock; writes/locks to a hardwired zero register vanish.
  always_comb begin
    wr_en    = (mem_instr == OP_REG_WRITE) && !zero_z;
    lock_eff = lock_en && !zero_lock;
  end

  // Byte-merge the incoming data over the current contents of reg[sel_z].
  always_comb begin
    wr_old    = regs[sel_z];
    wr_merged = wr_old;
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        wr_merged[8*i +: 8] = mem_data[8*i +: 8];
      end
    end
  end

  // Address matches between the write/lock ports and the two read ports.
  always_comb begin
    wr_hit_x   = wr_en && (sel_z == sel_x);
    wr_hit_y   = wr_en && (sel_z == sel_y);
    lock_hit_x = lock_eff && (lock_sel == sel_x);
    lock_hit_y = lock_eff && (lock_sel == sel_y);
  end

  // Read muxes with bypass of the merged write value.
  always_comb begin
    if (zero_x) begin
      a_next = '0;
    end else if (wr_hit_x) begin
      a_next = wr_merged;
    end else begin
      a_next = regs[sel_x];
    end

    if (zero_y) begin
      b_next = '0;
    end else if (wr_hit_y) begin
      b_next = wr_merged;
    end else begin
      b_next = regs[sel_y];
    end
  end

  // Scoreboard next state: a write releases its target, a lock then claims
  // its target, so a lock and write on the same index leave it busy.
  always_comb begin
    busy_next = busy;
    if (wr_en) begin
      busy_next[sel_z] = 1'b0;
    end
    if (lock_eff) begin
      busy_next[lock_sel] = 1'b1;
    end
  end

  // A source blocks the read if it is busy now and is not being released by
  // a write this cycle (a same-cycle re-lock keeps it blocked).
  always_comb begin
    x_blocked     = busy[sel_x] && !(wr_hit_x && !lock_hit_x);
    y_blocked     = busy[sel_y] && !(wr_hit_y && !lock_hit_y);
    rd_valid_next = rd_req && !x_blocked && !y_blocked;
  end

  // Register array storage; reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[sel_z] <= wr_merged;
    end
  end

  // Registered read ports, valid flag and scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      a        <= '0;
      b        <= '0;
      rd_valid <= 1'b0;
      busy     <= '0;
    end else begin
      a        <= a_next;
      b        <= b_next;
      rd_valid <= rd_valid_next;
      busy     <= busy_next;
    end
  end

  // Bus acknowledge delayed by exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_ack_out <= 1'b0;
    end else begin
      data_ack_out <= data_ack_in;
    end
  end

endmodule
